uop_expander: RTL and testbench



---
 rtl/uop_expander.sv | 192 +++++++++++++++++++
 tb/tb_uop_expander.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uop_expander.sv
// Expands microcoded (tensor) instructions into uop sequences from a run-time table; others pass through.
// Define UOP_EXPANDER_OUTREG_EN to register out_* through a 2-entry skid buffer (+1 cycle, no comb in->out path).
module uop_expander #(
  parameter int DEPTH  = 64,
  parameter int NR_W   = 6,
  parameter int HDR_W  = 48,
  parameter int BODY_W = 128,
  parameter int REP_W  = 3,
  parameter int STRIDE = 8,
  localparam int UPC_W = $clog2(DEPTH),
  localparam int ENT_W = 1 + UPC_W + REP_W + 4 + BODY_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_uop_en,
  input  logic [UPC_W-1:0]  in_entry,
  input  logic [NR_W-1:0]   in_reg_base,
  input  logic [HDR_W-1:0]  in_hdr,
  input  logic [BODY_W-1:0] in_body,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HDR_W-1:0]  out_hdr,
  output logic [BODY_W-1:0] out_body,
  output logic              out_last,
  input  logic              ucode_we,
  input  logic [UPC_W-1:0]  ucode_addr,
  input  logic [ENT_W-1:0]  ucode_wdata,
  output logic              ucode_busy
);

  typedef enum logic {S_IDLE, S_SEQ} state_t;

  localparam logic [NR_W-1:0] STRIDE_N = NR_W'(STRIDE);

  state_t             r_state;
  logic [UPC_W-1:0]   r_upc;
  logic [REP_W-1:0]   r_iter;
  logic               r_busy;
  logic [ENT_W-1:0]   r_mem [DEPTH];

  logic [UPC_W-1:0]   w_upc;
  logic [REP_W-1:0]   w_iter;
  logic [ENT_W-1:0]   w_ent;
  logic [BODY_W-1:0]  w_ent_body;
  logic [3:0]         w_ent_rel;
  logic [REP_W-1:0]   w_ent_rep;
  logic [UPC_W-1:0]   w_ent_next;
  logic               w_ent_fin;
  logic [NR_W-1:0]    w_iter_off;
  logic [NR_W-1:0]    w_delta;
  logic [BODY_W-1:0]  w_reloc_body;
  logic               w_uop_mode;
  logic               w_final;
  logic               w_fire;
  logic               w_we_ok;

  // Producer side of the output stage (before the optional skid buffer)
  logic               w_p_vld;
  logic               w_p_rdy;
  logic [HDR_W-1:0]   w_p_hdr;
  logic [BODY_W-1:0]  w_p_body;
  logic               w_p_last;

  // The first uop is read straight from in_entry so a sequence starts with no bubble.
  assign w_upc      = (r_state == S_SEQ) ? r_upc  : in_entry;
  assign w_iter     = (r_state == S_SEQ) ? r_iter : '0;
  assign w_uop_mode = (r_state == S_SEQ) | (in_valid & in_uop_en);

  assign w_ent      = r_mem[w_upc];
  assign w_ent_body = w_ent[BODY_W-1:0];
  assign w_ent_rel  = w_ent[BODY_W +: 4];
  assign w_ent_rep  = w_ent[BODY_W+4 +: REP_W];
  assign w_ent_next = w_ent[BODY_W+4+REP_W +: UPC_W];
  assign w_ent_fin  = w_ent[ENT_W-1];

  assign w_iter_off = NR_W'(w_iter) * STRIDE_N;
  assign w_delta    = in_reg_base + w_iter_off;

  // relmask bit k selects register field k; rd sits at k=3 (MSBs), rs3 at k=0.
  always_comb begin
    w_reloc_body = w_ent_body;
    for (int k = 0; k < 4; k++) begin
      if (w_ent_rel[k]) begin
        w_reloc_body[k*NR_W +: NR_W] = w_ent_body[k*NR_W +: NR_W] + w_delta;
      end
    end
  end

  assign w_final  = (w_iter >= w_ent_rep) & w_ent_fin;

  assign w_p_vld  = ~reset & ((r_state == S_SEQ) | in_valid);
  assign w_p_hdr  = in_hdr;
  assign w_p_body = w_uop_mode ? w_reloc_body : in_body;
  assign w_p_last = w_p_vld & (w_uop_mode ? w_final : 1'b1);
  assign w_fire   = w_p_vld & w_p_rdy;

  assign in_ready   = ~reset & (w_uop_mode ? (w_fire & w_final) : w_p_rdy);
  assign ucode_busy = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_upc   <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
    end else if (w_fire && w_uop_mode) begin
      if (w_iter < w_ent_rep) begin
        r_iter  <= w_iter + REP_W'(1);
        r_upc   <= w_upc;
        r_state <= S_SEQ;
        r_busy  <= 1'b1;
      end else if (!w_ent_fin) begin
        r_iter  <= '0;
        r_upc   <= w_ent_next;
        r_state <= S_SEQ;
        r_busy  <= 1'b1;
      end else begin
        r_iter  <= '0;
        r_upc   <= '0;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  // Writes are dropped while a sequence is reading the table, including its first uop.
  assign w_we_ok = ucode_we & ~r_busy & ~(w_uop_mode & w_fire);

  always_ff @(posedge clk) begin
    if (w_we_ok) begin
      r_mem[ucode_addr] <= ucode_wdata;
    end
  end

`ifdef UOP_EXPANDER_OUTREG_EN
  logic               r_o_vld;
  logic [HDR_W-1:0]   r_o_hdr;
  logic [BODY_W-1:0]  r_o_body;
  logic               r_o_last;
  logic               r_s_vld;
  logic [HDR_W-1:0]   r_s_hdr;
  logic [BODY_W-1:0]  r_s_body;
  logic               r_s_last;

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
  assign w_p_rdy = ~r_s_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_o_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (!r_o_vld || out_ready) begin
      if (r_s_vld) begin
        r_o_vld  <= 1'b1;
        r_o_hdr  <= r_s_hdr;
        r_o_body <= r_s_body;
        r_o_last <= r_s_last;
        r_s_vld  <= 1'b0;
      end else begin
        r_o_vld  <= w_fire;
        r_o_hdr  <= w_p_hdr;
        r_o_body <= w_p_body;
        r_o_last <= w_p_last;
      end
    end else if (w_fire) begin
      r_s_vld  <= 1'b1;
      r_s_hdr  <= w_p_hdr;
      r_s_body <= w_p_body;
      r_s_last <= w_p_last;
    end
  end

  assign out_valid = r_o_vld;
  assign out_hdr   = r_o_hdr;
  assign out_body  = r_o_body;
  assign out_last  = r_o_vld & r_o_last;
`else
  assign w_p_rdy   = out_ready;
  assign out_valid = w_p_vld;
  assign out_hdr   = w_p_hdr;
  assign out_body  = w_p_body;
  assign out_last  = w_p_last;
`endif

`ifndef SYNTHESIS
  // Upstream must hold the microcoded instruction until its final uop is accepted.
  a_hold_in_valid: assert property (@(posedge clk) disable iff (reset) (r_state == S_SEQ) |-> in_valid);
`endif

endmodule

// File: tb/tb_uop_expander.sv
// Directed bench for uop_expander: scoreboard of expected uops checked on every output fire.
module tb_uop_expander;

  localparam logic [103:0] TAG = 104'hC0FFEE0000123456789ABCDEF0;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_uop_en;
  logic [5:0]    in_entry;
  logic [5:0]    in_reg_base;
  logic [47:0]   in_hdr;
  logic [127:0]  in_body;
  logic          out_valid;
  logic          out_ready;
  logic [47:0]   out_hdr;
  logic [127:0]  out_body;
  logic          out_last;
  logic          ucode_we;
  logic [5:0]    ucode_addr;
  logic [141:0]  ucode_wdata;
  logic          ucode_busy;

  typedef struct packed {
    logic [47:0]  hdr;
    logic [127:0] body;
    logic         last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  uop_expander dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop_en(in_uop_en),
    .in_entry(in_entry), .in_reg_base(in_reg_base), .in_hdr(in_hdr), .in_body(in_body),
    .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
    .out_body(out_body), .out_last(out_last),
    .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_wdata(ucode_wdata),
    .ucode_busy(ucode_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mkb(input logic [5:0] rd, input logic [5:0] rs1,
                                       input logic [5:0] rs2, input logic [5:0] rs3);
    return {TAG, rd, rs1, rs2, rs3};
  endfunction

  function automatic logic [141:0] mke(input logic fin, input logic [5:0] nxt, input logic [2:0] rep,
                                       input logic [3:0] rm, input logic [127:0] body);
    return {fin, nxt, rep, rm, body};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [47:0] h, input logic [127:0] b, input logic l);
    exp_t e;
    e.hdr  = h;
    e.body = b;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [5:0] a, input logic [141:0] d);
    ucode_we    = 1'b1;
    ucode_addr  = a;
    ucode_wdata = d;
    @(posedge clk); #1;
    ucode_we    = 1'b0;
  endtask

  // Presents one instruction until accepted; rdy_pat bit n drives out_ready in cycle n.
  task automatic run_instr(input logic en, input logic [5:0] ent, input logic [5:0] base,
                           input logic [47:0] hdr, input logic [127:0] body,
                           input logic [15:0] rdy_pat, input logic [127:0] stall_exp,
                           input int exp_cycles);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1; in_uop_en = en; in_entry = ent; in_reg_base = base;
    in_hdr = hdr; in_body = body;
    while (!done && n < 40) begin
      out_ready = (n < 16) ? rdy_pat[n] : 1'b1;
      @(negedge clk);
      if (!out_ready) begin
        chk("stall_body", out_body, stall_exp);
        chk("stall_in_ready", in_ready, 0);
      end
      done = in_ready;
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_uop_en = 1'b0; out_ready = 1'b1;
    chk("consumed", done, 1);
    chk("uop_cycles", n, exp_cycles);
    if (!done) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_uop: observed body %0h expected no uop", out_body);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_hdr", out_hdr, mon_e.hdr);
        chk("sb_body", out_body, mon_e.body);
        chk("sb_last", out_last, mon_e.last);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_uop_en = 1'b0; in_entry = '0; in_reg_base = '0;
    in_hdr = '0; in_body = '0; out_ready = 1'b0; ucode_we = 1'b0; ucode_addr = '0; ucode_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", ucode_busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;

    wr(6'd0,  mke(1'b0, 6'd5, 3'd0, 4'b1000, mkb(6'd2, 6'd1, 6'd1, 6'd1)));
    wr(6'd5,  mke(1'b1, 6'd0, 3'd0, 4'b0000, mkb(6'd3, 6'd0, 6'd0, 6'd0)));
    wr(6'd10, mke(1'b1, 6'd0, 3'd3, 4'b1111, mkb(6'd0, 6'd0, 6'd0, 6'd0)));
    wr(6'd11, mke(1'b1, 6'd0, 3'd0, 4'b1000, mkb(6'd60, 6'd0, 6'd0, 6'd0)));
    wr(6'd20, mke(1'b1, 6'd0, 3'd0, 4'b0000, mkb(6'd5, 6'd6, 6'd7, 6'd8)));
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", ucode_busy, 0);
    @(posedge clk); #1;

    // Passthrough, same-cycle accept and then with one stall cycle
    push(48'h1111_2222_3333, 128'hABCD, 1'b1);
    run_instr(1'b0, 6'd0, 6'd0, 48'h1111_2222_3333, 128'hABCD, 16'hFFFF, '0, 1);
    push(48'h1111_2222_4444, 128'h1234, 1'b1);
    run_instr(1'b0, 6'd0, 6'd0, 48'h1111_2222_4444, 128'h1234, 16'hFFFE, 128'h1234, 2);

    // Two-entry chain: rd relocated on entry 0 only
    push(48'hAAAA_0000_0001, mkb(6'd10, 6'd1, 6'd1, 6'd1), 1'b0);
    push(48'hAAAA_0000_0001, mkb(6'd3, 6'd0, 6'd0, 6'd0), 1'b1);
    run_instr(1'b1, 6'd0, 6'd8, 48'hAAAA_0000_0001, 128'hDEAD, 16'hFFFF, '0, 2);

    // Repeat with stride, then rd wrap-around
    push(48'hAAAA_0000_0002, mkb(6'd0, 6'd0, 6'd0, 6'd0), 1'b0);
    push(48'hAAAA_0000_0002, mkb(6'd8, 6'd8, 6'd8, 6'd8), 1'b0);
    push(48'hAAAA_0000_0002, mkb(6'd16, 6'd16, 6'd16, 6'd16), 1'b0);
    push(48'hAAAA_0000_0002, mkb(6'd24, 6'd24, 6'd24, 6'd24), 1'b1);
    run_instr(1'b1, 6'd10, 6'd0, 48'hAAAA_0000_0002, 128'h0, 16'hFFFF, '0, 4);
    push(48'hAAAA_0000_0003, mkb(6'd4, 6'd0, 6'd0, 6'd0), 1'b1);
    run_instr(1'b1, 6'd11, 6'd8, 48'hAAAA_0000_0003, 128'h0, 16'hFFFF, '0, 1);

    // Backpressure 1,0,0,1 mid-sequence: the stalled uop is the iter-1 one
    push(48'hBBBB_0000_0001, mkb(6'd0, 6'd0, 6'd0, 6'd0), 1'b0);
    push(48'hBBBB_0000_0001, mkb(6'd8, 6'd8, 6'd8, 6'd8), 1'b0);
    push(48'hBBBB_0000_0001, mkb(6'd16, 6'd16, 6'd16, 6'd16), 1'b0);
    push(48'hBBBB_0000_0001, mkb(6'd24, 6'd24, 6'd24, 6'd24), 1'b1);
    run_instr(1'b1, 6'd10, 6'd0, 48'hBBBB_0000_0001, 128'h0, 16'hFFF9, mkb(6'd8, 6'd8, 6'd8, 6'd8), 6);

    // Table write during SEQ is dropped; the same write in IDLE lands next cycle
    push(48'hCCCC_0000_0001, mkb(6'd0, 6'd0, 6'd0, 6'd0), 1'b0);
    push(48'hCCCC_0000_0001, mkb(6'd8, 6'd8, 6'd8, 6'd8), 1'b0);
    push(48'hCCCC_0000_0001, mkb(6'd16, 6'd16, 6'd16, 6'd16), 1'b0);
    push(48'hCCCC_0000_0001, mkb(6'd24, 6'd24, 6'd24, 6'd24), 1'b1);
    fork
      run_instr(1'b1, 6'd10, 6'd0, 48'hCCCC_0000_0001, 128'h0, 16'hFFFF, '0, 4);
      begin
        @(posedge clk); #1;
        chk("busy_in_seq", ucode_busy, 1);
        ucode_we    = 1'b1;
        ucode_addr  = 6'd20;
        ucode_wdata = mke(1'b1, 6'd0, 3'd0, 4'b0000, mkb(6'd9, 6'd9, 6'd9, 6'd9));
        @(posedge clk); #1;
        ucode_we    = 1'b0;
      end
    join
    push(48'hCCCC_0000_0002, mkb(6'd5, 6'd6, 6'd7, 6'd8), 1'b1);
    run_instr(1'b1, 6'd20, 6'd0, 48'hCCCC_0000_0002, 128'h0, 16'hFFFF, '0, 1);
    wr(6'd20, mke(1'b1, 6'd0, 3'd0, 4'b0000, mkb(6'd9, 6'd9, 6'd9, 6'd9)));
    push(48'hCCCC_0000_0003, mkb(6'd9, 6'd9, 6'd9, 6'd9), 1'b1);
    run_instr(1'b1, 6'd20, 6'd0, 48'hCCCC_0000_0003, 128'h0, 16'hFFFF, '0, 1);

    // Reset while the second uop of a 4-uop sequence is presented
    push(48'hDDDD_0000_0001, mkb(6'd0, 6'd0, 6'd0, 6'd0), 1'b0);
    in_valid = 1'b1; in_uop_en = 1'b1; in_entry = 6'd10; in_reg_base = 6'd0;
    in_hdr = 48'hDDDD_0000_0001; in_body = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_seq_first_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_seq_out_valid", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_uop_en = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_busy", ucode_busy, 0);
    @(posedge clk); #1;
    push(48'hDDDD_0000_0002, mkb(6'd4, 6'd0, 6'd0, 6'd0), 1'b1);
    run_instr(1'b1, 6'd11, 6'd8, 48'hDDDD_0000_0002, 128'h0, 16'hFFFF, '0, 1);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
